// File: rtl/bpsk_mod_frame.sv
// BPSK/DBPSK frame modulator: serialises a latched frame MSB-first onto a signed sine-LUT sample stream.
// Optional preamble is enabled by defining BPSK_MOD_FRAME_PREAMBLE_EN.
module bpsk_mod_frame #(
  parameter int unsigned NUM_WORDS = 16,
  parameter int unsigned WORD_W    = 32,
  parameter int unsigned OUT_W     = 8,
  parameter int unsigned SPS_LOG2  = 4,
  parameter int unsigned DIV_W     = 3,
  parameter int unsigned PRE_LEN   = 8
) (
  input  logic                          Clk,
  input  logic                          Reset,
  input  logic                          Start,
  input  logic                          Mode,
  input  logic [DIV_W-1:0]              OutDiv,
  input  logic [NUM_WORDS*WORD_W-1:0]   Data,
  output logic                          Busy,
  output logic                          Done,
  output logic                          OutValid,
  output logic signed [OUT_W-1:0]       Out
);

  localparam int unsigned SPS   = 2**SPS_LOG2;
  localparam int unsigned NBITS = NUM_WORDS*WORD_W;
`ifdef BPSK_MOD_FRAME_PREAMBLE_EN
  localparam int unsigned TOTAL = PRE_LEN + NBITS;
  localparam int unsigned PRE_W = (PRE_LEN > 0) ? $clog2(PRE_LEN+1) : 1;
`else
  localparam int unsigned TOTAL = NBITS;
`endif
  localparam int unsigned SYM_W = (TOTAL > 1) ? $clog2(TOTAL) : 1;

  // Upper half is the exact negation of the lower half, keeping the table symmetric.
  function automatic logic [SPS*OUT_W-1:0] build_lut();
    real pi, amp, x, term, s;
    int v;
    logic signed [OUT_W-1:0] e;
    logic [SPS*OUT_W-1:0] t;
    pi  = 3.14159265358979323846;
    amp = 1.0;
    for (int unsigned i = 0; i < OUT_W-1; i++) amp = amp * 2.0;
    amp = amp - 1.0;
    t = '0;
    for (int unsigned k = 0; k < SPS/2; k++) begin
      x    = 2.0 * pi * real'(k) / real'(SPS);
      term = x;
      s    = x;
      for (int unsigned n = 1; n < 20; n++) begin
        term = -term * x * x / (real'(2*n) * real'(2*n+1));
        s    = s + term;
      end
      s = s * amp;
      v = (s >= 0.0) ? $rtoi(s + 0.5) : -$rtoi(0.5 - s);
      e = v[OUT_W-1:0];
      t[k*OUT_W +: OUT_W]         = e;
      t[(k+SPS/2)*OUT_W +: OUT_W] = -e;
    end
    return t;
  endfunction

  localparam logic [SPS*OUT_W-1:0] LUT = build_lut();

  typedef enum logic [1:0] {IDLE, TX, DONE} state_t;

  state_t              state_q, state_d;
  logic [NBITS-1:0]    data_q, data_d, ser_in;
  logic                mode_q, mode_d;
  logic [DIV_W-1:0]    div_q, div_d, div_cnt_q, div_cnt_d;
  logic [SPS_LOG2-1:0] k_q, k_d;
  logic [SYM_W-1:0]    sym_q, sym_d;
  logic                txp_q, txp_d;
  logic                tx;
  logic signed [OUT_W-1:0] sample;
`ifdef BPSK_MOD_FRAME_PREAMBLE_EN
  logic [PRE_W-1:0]    pre_q, pre_d;
  logic                pre_tx_q, pre_tx_d;
  logic                in_pre;
`endif

  // Word 0 lands in the top bits so the frame shifts out from the MSB.
  always_comb begin
    ser_in = '0;
    for (int unsigned i = 0; i < NUM_WORDS; i++)
      ser_in[(NUM_WORDS-1-i)*WORD_W +: WORD_W] = Data[i*WORD_W +: WORD_W];
  end

  always_comb begin
    state_d   = state_q;
    data_d    = data_q;
    mode_d    = mode_q;
    div_d     = div_q;
    div_cnt_d = div_cnt_q;
    k_d       = k_q;
    sym_d     = sym_q;
    txp_d     = txp_q;
    Busy      = 1'b0;
    Done      = 1'b0;
    OutValid  = 1'b0;
    Out       = '0;
    sample    = LUT[int'(k_q)*OUT_W +: OUT_W];
    tx        = mode_q ? (txp_q ^ ~data_q[NBITS-1]) : data_q[NBITS-1];
`ifdef BPSK_MOD_FRAME_PREAMBLE_EN
    pre_d    = pre_q;
    pre_tx_d = pre_tx_q;
    in_pre   = (pre_q != '0);
    if (in_pre) tx = pre_tx_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (Start) begin
          data_d    = ser_in;
          mode_d    = Mode;
          div_d     = OutDiv;
          div_cnt_d = '0;
          k_d       = '0;
          sym_d     = '0;
          txp_d     = 1'b1;
`ifdef BPSK_MOD_FRAME_PREAMBLE_EN
          pre_d     = PRE_W'(PRE_LEN);
          pre_tx_d  = 1'b1;
`endif
          state_d   = TX;
        end
      end
      TX: begin
        Busy     = 1'b1;
        OutValid = (div_cnt_q == '0);
        Out      = tx ? sample : -sample;
        if (div_cnt_q == div_q) begin
          div_cnt_d = '0;
          k_d       = k_q + 1'b1;
          if (k_q == '1) begin
            txp_d = tx;
            sym_d = sym_q + 1'b1;
`ifdef BPSK_MOD_FRAME_PREAMBLE_EN
            if (in_pre) begin
              pre_d    = pre_q - 1'b1;
              pre_tx_d = ~pre_tx_q;
            end else begin
              data_d = data_q << 1;
            end
`else
            data_d = data_q << 1;
`endif
            if (sym_q == SYM_W'(TOTAL-1)) state_d = DONE;
          end
        end else begin
          div_cnt_d = div_cnt_q + 1'b1;
        end
      end
      DONE: begin
        Done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q   <= IDLE;
      data_q    <= '0;
      mode_q    <= 1'b0;
      div_q     <= '0;
      div_cnt_q <= '0;
      k_q       <= '0;
      sym_q     <= '0;
      txp_q     <= 1'b0;
`ifdef BPSK_MOD_FRAME_PREAMBLE_EN
      pre_q     <= '0;
      pre_tx_q  <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      data_q    <= data_d;
      mode_q    <= mode_d;
      div_q     <= div_d;
      div_cnt_q <= div_cnt_d;
      k_q       <= k_d;
      sym_q     <= sym_d;
      txp_q     <= txp_d;
`ifdef BPSK_MOD_FRAME_PREAMBLE_EN
      pre_q     <= pre_d;
      pre_tx_q  <= pre_tx_d;
`endif
    end
  end

endmodule

// File: doc/bpsk_mod_frame.md
Name: bpsk_mod_frame

Overview:
Parametrised next-generation BPSK frame modulator. Accepts a frame of NUM_WORDS data words and serialises it MSB-first, one symbol per carrier period, onto a signed sine-LUT sample stream. Supports BPSK and differential BPSK (DBPSK), and a programmable sample-rate divider. It sits between the host register/frame buffer and the DAC sample path, replacing the fixed 16x32 modulator.

Parameters:
NUM_WORDS, 16, words per frame (>=1)
WORD_W, 32, bits per word (>=1)
OUT_W, 8, output sample width, two's complement (>=3)
SPS_LOG2, 4, log2 of samples per symbol; SPS = 2**SPS_LOG2 (>=2)
DIV_W, 3, width of OutDiv
PRE_LEN, 8, preamble symbols (used only with the optional feature)

Ports:
Clk  in  1  system clock, all logic on rising edge
Reset  in  1  asynchronous, active-high reset
Start  in  1  frame request; accepted only while Busy=0
Mode  in  1  0=BPSK, 1=DBPSK; sampled with Start
OutDiv  in  DIV_W  sample period = OutDiv+1 clocks; sampled with Start
Data  in  NUM_WORDS*WORD_W  frame; word i = Data[i*WORD_W +: WORD_W]; sampled with Start
Busy  out  1  frame in progress
Done  out  1  one-cycle pulse at frame end
OutValid  out  1  one-cycle strobe marking a new sample on Out
Out  out  OUT_W  signed carrier sample

Behaviour:
- Clock and reset: one clock, Clk. Reset is asynchronous and active-high. While Reset=1: Busy=0, Done=0, OutValid=0, Out=0, state=IDLE, all counters 0.
- LUT: SPS entries, LUT[k] = round((2**(OUT_W-1)-1) * sin(2*pi*k/SPS)), fixed at elaboration. The table is symmetric, so negation never overflows.
- Symbol mapping: tx symbol 1 -> Out = LUT[k]; tx symbol 0 -> Out = -LUT[k].
- Bit order: word 0 first, MSB first, then word 1, and so on. There are NUM_WORDS*WORD_W data symbols.
- BPSK: tx = d.
- DBPSK: tx_n = tx_(n-1) XOR ~d_n, with tx_(-1)=1 at the start of every frame. A data 1 keeps the phase; a data 0 flips it.
- States:
  - IDLE: on Start=1, latch Data, Mode and OutDiv into shadow registers, clear the counters, set Busy=1 and go to TX.
  - TX: emit samples.
  - DONE: one cycle; Done=1, Busy=0, Out=0, then go to IDLE.
- Sample timing:
  - The first OutValid occurs in the cycle after Start is accepted.
  - Subsequent OutValid strobes follow every OutDiv+1 clocks (OutDiv=0 gives OutValid=1 every cycle).
  - Out changes only with OutValid and holds between strobes.
- Counters: sample index k is SPS_LOG2 bits and wraps. The bit index advances when k wraps from SPS-1 to 0.
- Frame end: after the final sample (last symbol, k=SPS-1) has been held for OutDiv+1 cycles, enter DONE. Total TX cycles = NUM_WORDS*WORD_W*SPS*(OutDiv+1).
- Start handling:
  - Start while Busy=1 is ignored.
  - Start during the DONE cycle is also ignored; the earliest accepted Start is the cycle after Done.
- Inputs Data, Mode and OutDiv may change freely during TX; only the shadow copies are used.
- Reset asserted mid-frame aborts immediately: Out=0, no Done pulse.
- Idle: Out=0 and OutValid=0.

Optional Feature:
- Macro: BPSK_MOD_FRAME_PREAMBLE_EN.
- When defined:
  - PRE_LEN preamble symbols of alternating tx symbols 1,0,1,0,... are emitted before the data, using the same sample timing.
  - The preamble is not differentially encoded.
  - In DBPSK, tx_(-1) for the first data bit equals the last preamble tx symbol.
  - Total symbols = PRE_LEN + NUM_WORDS*WORD_W.
- When undefined: no preamble logic is present, PRE_LEN is unused, and the frame starts with data bit 0.

Test Plan:
Common configuration: NUM_WORDS=1, WORD_W=8, OUT_W=8, SPS_LOG2=2, so LUT = {0x00, 0x7F, 0x00, 0x81}.
1. BPSK, OutDiv=0, Data=0xA5, Start pulse -> 32 consecutive OutValid cycles. The first symbol (1) gives 00,7F,00,81; the second (0) gives 00,81,00,7F; the full pattern follows 1,0,1,0,0,1,0,1. Done pulses in the cycle after the 32nd sample; Busy goes 1 -> 0 then.
2. DBPSK, OutDiv=0, Data=0xFF -> all 8 symbols give 00,7F,00,81 (tx stays 1). Data=0x00 -> tx symbols 0,1,0,1,0,1,0,1.
3. BPSK, OutDiv=3, Data=0x80 -> OutValid every 4th cycle. Out holds each value for 4 cycles. Done occurs 128 cycles after Start acceptance +1.
4. Start re-pulsed at sample 10 with Data=0x00 and Mode=1 -> ignored; the output is identical to scenario 1. Start in the Done cycle is ignored; Start one cycle later is accepted.
5. Reset asserted at sample 17 of scenario 1 -> Out=0, OutValid=0 and Busy=0 asynchronously, with no Done. After release, a new Start with Data=0xA5 reproduces scenario 1 exactly.
6. With BPSK_MOD_FRAME_PREAMBLE_EN defined, PRE_LEN=2, BPSK, Data=0xFF -> the first 8 samples are 00,7F,00,81,00,81,00,7F, followed by 32 data samples; Done follows the 40th sample.
